// File: rtl/edge_thr_frame_ctrl.sv
// Frame sequencer and adaptive HIGH/LOW threshold controller for the Canny hysteresis stage.
// Build option: define ADAPTIVE_THR_EN to enable per-frame threshold adaptation.
module edge_thr_frame_ctrl #(
    parameter int IMG_W     = 256,
    parameter int IMG_H     = 256,
    parameter int CNT_W     = 17,
    parameter int HIGH_INIT = 155,
    parameter int GAP       = 25,
    parameter int STEP      = 4,
    parameter int TGT_LO    = 1000,
    parameter int TGT_HI    = 4000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             cont_i,
    input  logic             abort_i,
    input  logic             pix_valid_i,
    input  logic [1:0]       edge_type_i,
    output logic             pix_ready_o,
    output logic [7:0]       high_th_o,
    output logic [7:0]       low_th_o,
    output logic [CNT_W-1:0] strong_cnt_o,
    output logic [CNT_W-1:0] weak_cnt_o,
    output logic             frame_done_o,
    output logic             busy_o,
    output logic             ovf_o
);

    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [7:0] HIGH_RST = 8'(HIGH_INIT);
    localparam logic [7:0] LOW_RST  = (HIGH_INIT > GAP) ? 8'(HIGH_INIT - GAP) : 8'd0;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, UPDATE = 2'd2} state_e;

    state_e           state_q;
    logic [XW-1:0]    x_q;
    logic [YW-1:0]    y_q;
    logic [CNT_W-1:0] s_acc_q, w_acc_q, s_acc_d, w_acc_d;
    logic [CNT_W-1:0] scnt_q, wcnt_q;
    logic [7:0]       high_q, low_q, high_d, low_d;
    logic             ready_q, done_q, busy_q, ovf_q;
    logic             accept, last_px;

    assign accept  = pix_valid_i && ready_q;
    assign last_px = (x_q == XW'(IMG_W - 1)) && (y_q == YW'(IMG_H - 1));

    // Saturating accumulators; 2'b11 falls through as "none".
    always_comb begin
        s_acc_d = s_acc_q;
        w_acc_d = w_acc_q;
        if (edge_type_i == 2'b10 && s_acc_q != '1) s_acc_d = s_acc_q + 1'b1;
        if (edge_type_i == 2'b01 && w_acc_q != '1) w_acc_d = w_acc_q + 1'b1;
    end

    always_comb begin
        high_d = high_q;
`ifdef ADAPTIVE_THR_EN
        if (int'(s_acc_q) > TGT_HI)
            high_d = (int'(high_q) + STEP > 255) ? 8'd255 : 8'(int'(high_q) + STEP);
        else if (int'(s_acc_q) < TGT_LO)
            high_d = (int'(high_q) - STEP < GAP + 1) ? 8'(GAP + 1) : 8'(int'(high_q) - STEP);
`endif
        low_d = (int'(high_d) > GAP) ? 8'(int'(high_d) - GAP) : 8'd0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            s_acc_q <= '0;
            w_acc_q <= '0;
            scnt_q  <= '0;
            wcnt_q  <= '0;
            high_q  <= HIGH_RST;
            low_q   <= LOW_RST;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (pix_valid_i && !ready_q) ovf_q <= 1'b1;
            if (abort_i) begin
                state_q <= IDLE;
                ready_q <= 1'b0;
                busy_q  <= 1'b0;
                x_q     <= '0;
                y_q     <= '0;
                s_acc_q <= '0;
                w_acc_q <= '0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        x_q     <= '0;
                        y_q     <= '0;
                        s_acc_q <= '0;
                        w_acc_q <= '0;
                        if (start_i) begin
                            state_q <= RUN;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (accept) begin
                            s_acc_q <= s_acc_d;
                            w_acc_q <= w_acc_d;
                            if (x_q == XW'(IMG_W - 1)) begin
                                x_q <= '0;
                                y_q <= y_q + 1'b1;
                            end else begin
                                x_q <= x_q + 1'b1;
                            end
                            // Pulse lands in the UPDATE cycle; results follow one cycle later.
                            if (last_px) begin
                                state_q <= UPDATE;
                                ready_q <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    UPDATE: begin
                        scnt_q  <= s_acc_q;
                        wcnt_q  <= w_acc_q;
                        high_q  <= high_d;
                        low_q   <= low_d;
                        x_q     <= '0;
                        y_q     <= '0;
                        s_acc_q <= '0;
                        w_acc_q <= '0;
                        if (cont_i) begin
                            state_q <= RUN;
                            ready_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign pix_ready_o  = ready_q;
    assign high_th_o    = high_q;
    assign low_th_o     = low_q;
    assign strong_cnt_o = scnt_q;
    assign weak_cnt_o   = wcnt_q;
    assign frame_done_o = done_q;
    assign busy_o       = busy_q;
    assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_edge_thr_frame_ctrl.sv
// Self-checking bench for edge_thr_frame_ctrl: frame table, scoreboard of per-frame results, corner sequences.
module tb_edge_thr_frame_ctrl;

    localparam int IMG_W = 4, IMG_H = 2, CNT_W = 8;
    localparam int HIGH_INIT = 155, GAP = 25, STEP = 4, TGT_LO = 2, TGT_HI = 5;

    logic             clk = 1'b0;
    logic             rst, start, cont, abort, pix_valid;
    logic [1:0]       edge_type;
    logic             pix_ready, frame_done, busy, ovf;
    logic [7:0]       high_th, low_th;
    logic [CNT_W-1:0] strong_cnt, weak_cnt;

    edge_thr_frame_ctrl #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .CNT_W(CNT_W), .HIGH_INIT(HIGH_INIT),
        .GAP(GAP), .STEP(STEP), .TGT_LO(TGT_LO), .TGT_HI(TGT_HI)
    ) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .cont_i(cont), .abort_i(abort),
        .pix_valid_i(pix_valid), .edge_type_i(edge_type), .pix_ready_o(pix_ready),
        .high_th_o(high_th), .low_th_o(low_th), .strong_cnt_o(strong_cnt),
        .weak_cnt_o(weak_cnt), .frame_done_o(frame_done), .busy_o(busy), .ovf_o(ovf)
    );

    always #5 clk = ~clk;

    typedef struct { logic [15:0] pix; int s; int w; } vec_t;
    typedef struct { int s; int w; int h; int l; } exp_t;

    exp_t sb[$];
    vec_t tbl[7];
    int   n_cmp = 0, n_err = 0, done_seen = 0;
    int   mh = HIGH_INIT, ml = HIGH_INIT - GAP, last_s = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Reference threshold model applied when a frame's expectation is queued.
    task automatic push_exp(input int s, input int w);
        exp_t e;
`ifdef ADAPTIVE_THR_EN
        if (s > TGT_HI) mh = (mh + STEP > 255) ? 255 : mh + STEP;
        else if (s < TGT_LO) mh = (mh - STEP < GAP + 1) ? GAP + 1 : mh - STEP;
`endif
        ml = (mh > GAP) ? mh - GAP : 0;
        last_s = s;
        e.s = s; e.w = w; e.h = mh; e.l = ml;
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && frame_done) begin
                done_seen++;
                if (sb.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL fd_unexpected: frame_done with no frame queued");
                end else begin
                    e = sb.pop_front();
                    @(negedge clk);
                    chk("fd_one_cycle", int'(frame_done), 0);
                    chk("strong_cnt", int'(strong_cnt), e.s);
                    chk("weak_cnt", int'(weak_cnt), e.w);
                    chk("high_th", int'(high_th), e.h);
                    chk("low_th", int'(low_th), e.l);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic run_frame(input logic [15:0] pix, input bit do_start, input bit cnt,
                             input bit extra, input int es, input int ew);
        cont = cnt;
        if (do_start) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            chk("ready_after_start", int'(pix_ready), 1);
        end
        push_exp(es, ew);
        for (int i = 0; i < IMG_W * IMG_H; i++) begin
            pix_valid = 1'b1;
            edge_type = pix[2*i +: 2];
            @(posedge clk); #1;
        end
        pix_valid = extra;
        edge_type = 2'b10;
        chk("ready_low_update", int'(pix_ready), 0);
        chk("fd_after_last", int'(frame_done), 1);
        @(posedge clk); #1;
        pix_valid = 1'b0;
        chk("ready_after_update", int'(pix_ready), int'(cnt));
        chk("busy_after_update", int'(busy), int'(cnt));
    endtask

    initial begin : stim
        int ds;
        tbl[0] = '{16'h1AAA, 6, 1};
        tbl[1] = '{16'h0015, 0, 3};
        tbl[2] = '{16'h0D6A, 3, 2};
        tbl[3] = '{16'hFEAA, 5, 0};
        tbl[4] = '{16'h555A, 2, 6};
        tbl[5] = '{16'hAAAA, 8, 0};
        tbl[6] = '{16'hFFFF, 0, 0};

        rst = 1'b1; start = 1'b0; cont = 1'b0; abort = 1'b0; pix_valid = 1'b0; edge_type = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_high_th", int'(high_th), 155);
        chk("rst_low_th", int'(low_th), 130);
        chk("rst_ready", int'(pix_ready), 0);
        chk("rst_strong", int'(strong_cnt), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ovf", int'(ovf), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            run_frame(tbl[i].pix, 1'b1, 1'b0, 1'b0, tbl[i].s, tbl[i].w);
            @(posedge clk); #1;
        end
        chk("ovf_clean", int'(ovf), 0);

        // Continuous zero-strong frames walk HIGH down to its floor.
        for (int k = 0; k < 34; k++)
            run_frame(16'h0000, k == 0, k != 33, 1'b0, 0, 0);
        @(posedge clk); #1;
`ifdef ADAPTIVE_THR_EN
        chk("floor_high", int'(high_th), 26);
        chk("floor_low", int'(low_th), 1);
`else
        chk("fixed_high", int'(high_th), 155);
        chk("fixed_low", int'(low_th), 130);
`endif

        // Abort coincident with the last pixel wins.
        ds = done_seen;
        cont = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < IMG_W * IMG_H; i++) begin
            pix_valid = 1'b1;
            edge_type = 2'b10;
            abort = (i == IMG_W * IMG_H - 1);
            @(posedge clk); #1;
        end
        abort = 1'b0; pix_valid = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_ready", int'(pix_ready), 0);
        chk("abort_no_fd", int'(frame_done), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("abort_fd_count", done_seen, ds);
        chk("abort_high_kept", int'(high_th), mh);
        chk("abort_low_kept", int'(low_th), ml);
        chk("abort_strong_kept", int'(strong_cnt), last_s);
        run_frame(16'hAAAA, 1'b1, 1'b0, 1'b0, 8, 0);
        @(posedge clk); #1;

        // A pixel offered during UPDATE is dropped and flags overflow.
        run_frame(16'h0015, 1'b1, 1'b1, 1'b1, 0, 3);
        run_frame(16'h0000, 1'b0, 1'b0, 1'b0, 0, 0);
        chk("ovf_set", int'(ovf), 1);
        repeat (3) @(posedge clk);
        #1;
        chk("ovf_sticky", int'(ovf), 1);

        // Reset mid-frame restores everything.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pix_valid = 1'b1; edge_type = 2'b10;
            @(posedge clk); #1;
        end
        pix_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mh = HIGH_INIT; ml = HIGH_INIT - GAP;
        chk("mid_rst_high", int'(high_th), 155);
        chk("mid_rst_low", int'(low_th), 130);
        chk("mid_rst_strong", int'(strong_cnt), 0);
        chk("mid_rst_weak", int'(weak_cnt), 0);
        chk("mid_rst_ovf", int'(ovf), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_ready", int'(pix_ready), 0);
        run_frame(tbl[0].pix, 1'b1, 1'b0, 1'b0, tbl[0].s, tbl[0].w);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
